keypad_key_fifo: RTL and testbench

Event queue between the keypad debouncer and the keypad controller. It turns each debounced key press (a rising edge of `key_valid`) into exactly one queued 4-bit key code, and buffers up to DEPTH codes. The controller drains the queue with a valid/ready handshake, so presses that arrive while the controller is busy are not lost. The block runs in the 3 MHz HSOSC-derived clock domain.

---
 rtl/keypad_key_fifo.sv | 149 ++++++++++++++
 tb/tb_keypad_key_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_key_fifo.sv
// keypad_key_fifo: queue between the keypad debouncer and the keypad controller.
// Each rising edge of key_valid queues one 4-bit key code. The controller
// drains the queue through a valid/ready handshake.
//
// Optional feature: define KEY_FIFO_AUTOREPEAT_EN to enable auto-repeat of a
// held key (first repeat after REPEAT_DELAY cycles, then every REPEAT_PERIOD).
//
// Ports:
//   clk            system clock (3 MHz)
//   reset          synchronous active-high reset
//   key_valid      debounced key-held level
//   key_code       decoded key code, stable while key_valid=1
//   key_out        code at the queue head (don't-care when empty)
//   key_out_valid  queue non-empty
//   key_out_ready  consumer accepts the head this cycle
//   count          occupied entries
//   full           count == DEPTH
//   overflow       sticky: a press was dropped because the queue was full
module keypad_key_fifo #(
  parameter int unsigned DEPTH         = 4,
  parameter int unsigned REPEAT_DELAY  = 1500000,
  parameter int unsigned REPEAT_PERIOD = 300000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     key_valid,
  input  logic [3:0]               key_code,
  output logic [3:0]               key_out,
  output logic                     key_out_valid,
  input  logic                     key_out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  // Elaboration-time sanity checks on the configuration.
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("keypad_key_fifo: DEPTH must be a power of two >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("keypad_key_fifo: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic           key_valid_q, key_valid_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [3:0]     mem_q [DEPTH];

  logic           press;
  logic           rep_tick;
  logic           push_req;
  logic           pop;
  logic           push_acc;

`ifdef KEY_FIFO_AUTOREPEAT_EN
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  logic [RW-1:0]  rep_cnt_q, rep_cnt_d;
  logic           rep_armed_q, rep_armed_d;

  // The counter restarts from zero after every tick; rep_armed selects
  // the initial delay or the repeat period as the terminal count.
  always_comb begin
    rep_cnt_d   = '0;
    rep_armed_d = 1'b0;
    rep_tick    = 1'b0;
    if (key_valid && key_valid_q) begin
      rep_armed_d = rep_armed_q;
      if (rep_cnt_q == (rep_armed_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1))) begin
        rep_tick    = 1'b1;
        rep_cnt_d   = '0;
        rep_armed_d = 1'b1;
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`else
  always_comb begin
    rep_tick = 1'b0;
  end
`endif

  always_comb begin
    key_valid_d   = key_valid;
    press         = key_valid & ~key_valid_q;
    push_req      = press | rep_tick;
    key_out_valid = (count_q != '0);
    full          = (count_q == CW'(DEPTH));
    pop           = key_out_valid & key_out_ready;
    push_acc      = push_req & (~full | pop);

    wr_ptr_d   = push_acc ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop      ? rd_ptr_q + 1'b1 : rd_ptr_q;
    overflow_d = overflow_q | (push_req & ~push_acc);

    count_d = count_q;
    case ({push_acc, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    key_out  = mem_q[rd_ptr_q];
    count    = count_q;
    overflow = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Held key through reset must not look like a fresh press.
      key_valid_q <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
    end else begin
      key_valid_q <= key_valid_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
    end
  end

  // Storage is not reset; only written on accepted pushes.
  always_ff @(posedge clk) begin
    if (!reset && push_acc) begin
      mem_q[wr_ptr_q] <= key_code;
    end
  end

endmodule

// File: tb/tb_keypad_key_fifo.sv
module tb_keypad_key_fifo;

  localparam int TB_DEPTH  = 4;
  localparam int TB_DELAY  = 20;
  localparam int TB_PERIOD = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] key_out;
  logic       key_out_valid;
  logic       key_out_ready;
  logic [2:0] count;
  logic       full;
  logic       overflow;

  keypad_key_fifo #(
    .DEPTH(TB_DEPTH),
    .REPEAT_DELAY(TB_DELAY),
    .REPEAT_PERIOD(TB_PERIOD)
  ) dut (
    .clk(clk),
    .reset(reset),
    .key_valid(key_valid),
    .key_code(key_code),
    .key_out(key_out),
    .key_out_valid(key_out_valid),
    .key_out_ready(key_out_ready),
    .count(count),
    .full(full),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue contents, sticky overflow, previous key level,
  // and number of cycles the key has been held since its press.
  logic [3:0] mq[$];
  logic [3:0] exp_q[$];
  logic [3:0] popped[$];
  logic       m_ovf   = 1'b0;
  logic       m_prev  = 1'b1;
  int         m_hold  = 0;
  logic       started = 1'b0;

  always @(posedge clk) begin
    logic m_pop, m_press, m_tick;
    started <= 1'b1;
    if (reset) begin
      mq.delete();
      exp_q.delete();
      m_ovf  = 1'b0;
      m_prev = 1'b1;
      m_hold = 0;
    end else begin
      m_pop   = (mq.size() > 0) && key_out_ready;
      m_press = key_valid && !m_prev;
      m_tick  = 1'b0;
      if (m_press) begin
        m_hold = 0;
      end else if (key_valid) begin
        m_hold++;
`ifdef KEY_FIFO_AUTOREPEAT_EN
        if (m_hold >= TB_DELAY && ((m_hold - TB_DELAY) % TB_PERIOD) == 0) m_tick = 1'b1;
`endif
      end else begin
        m_hold = 0;
      end
      if (m_pop) void'(mq.pop_front());
      if (m_press || m_tick) begin
        if (mq.size() < TB_DEPTH) begin
          mq.push_back(key_code);
          exp_q.push_back(key_code);
        end else begin
          m_ovf = 1'b1;
        end
      end
      m_prev = key_valid;
    end
  end

  // Monitor: status every cycle, head value on every handshake.
  always @(negedge clk) begin
    if (started) begin
      chk("count", 32'(count), 32'(mq.size()));
      chk("key_out_valid", 32'(key_out_valid), 32'(mq.size() > 0));
      chk("full", 32'(full), 32'(mq.size() == TB_DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("count_bound", 32'(count <= TB_DEPTH), 32'd1);
      if (key_out_valid && key_out_ready && !reset) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pop", 32'd1, 32'd0);
        end else begin
          chk("key_out", 32'(key_out), 32'(exp_q.pop_front()));
          popped.push_back(key_out);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_key(input logic [3:0] c);
    key_code  = c;
    key_valid = 1'b1;
    cyc(1);
    key_valid = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(1);
  endtask

  task automatic chk_popped(input string name, input logic [3:0] exp[$]);
    chk({name, "_len"}, 32'(popped.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < popped.size(); i++)
      chk(name, 32'(popped[i]), 32'(exp[i]));
    popped.delete();
  endtask

  initial begin
    reset         = 1'b1;
    key_valid     = 1'b0;
    key_code      = 4'h0;
    key_out_ready = 1'b0;
    cyc(3);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_valid", 32'(key_out_valid), 32'd0);
    chk("reset_overflow", 32'(overflow), 32'd0);
    reset = 1'b0;
    cyc(1);

    // Single held press: one entry, visible one cycle after sampling.
    key_code  = 4'h5;
    key_valid = 1'b1;
    chk("latency_before", 32'(key_out_valid), 32'd0);
    cyc(1);
    chk("latency_after", 32'(key_out_valid), 32'd1);
    cyc(9);
    chk("held_count", 32'(count), 32'd1);
    chk("held_key_out", 32'(key_out), 32'h5);
    key_valid = 1'b0;
    key_out_ready = 1'b1;
    cyc(3);
    key_out_ready = 1'b0;
    popped.delete();

    // Overfill: fifth press dropped, overflow sticky.
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    press_key(4'h6);
    chk("ovf_full", 32'(full), 32'd1);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_count", 32'(count), 32'd4);
    key_out_ready = 1'b1;
    cyc(6);
    key_out_ready = 1'b0;
    chk_popped("ovf_drain", '{4'h1, 4'h2, 4'h3, 4'h4});
    chk("ovf_sticky", 32'(overflow), 32'd1);
    do_reset();

    // Full queue, press and pop in the same cycle.
    press_key(4'h1);
    press_key(4'h2);
    press_key(4'h3);
    press_key(4'h4);
    key_code      = 4'h9;
    key_valid     = 1'b1;
    key_out_ready = 1'b1;
    cyc(1);
    chk("fullpop_count", 32'(count), 32'd4);
    chk("fullpop_ovf", 32'(overflow), 32'd0);
    key_valid = 1'b0;
    popped.delete();
    cyc(6);
    key_out_ready = 1'b0;
    chk_popped("fullpop_drain", '{4'h2, 4'h3, 4'h4, 4'h9});

    // Key held through reset is not queued; a re-press is.
    key_code  = 4'h7;
    key_valid = 1'b1;
    reset     = 1'b1;
    cyc(3);
    reset = 1'b0;
    cyc(5);
    chk("hold_reset_count", 32'(count), 32'd0);
    key_valid = 1'b0;
    cyc(1);
    press_key(4'h7);
    chk("repress_count", 32'(count), 32'd1);
    key_out_ready = 1'b1;
    cyc(2);
    key_out_ready = 1'b0;
    popped.delete();

    // Interleaved push/pop with ready toggling every cycle, across pointer wrap.
    begin
      logic [3:0] expv[$];
      for (int i = 0; i < 3 * TB_DEPTH; i++) begin
        key_code      = 4'(i + 1);
        key_valid     = 1'b1;
        key_out_ready = ~key_out_ready;
        cyc(1);
        key_valid     = 1'b0;
        key_out_ready = ~key_out_ready;
        cyc(1);
        expv.push_back(4'(i + 1));
      end
      key_out_ready = 1'b1;
      cyc(TB_DEPTH + 2);
      key_out_ready = 1'b0;
      chk("interleave_ovf", 32'(overflow), 32'd0);
      chk_popped("interleave", expv);
    end

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 800; i++) begin
      reset         = ($urandom_range(0, 199) == 0);
      key_out_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) begin
        if (!key_valid) key_code = 4'($urandom_range(0, 15));
        key_valid = ~key_valid;
      end
      cyc(1);
    end
    reset         = 1'b0;
    key_valid     = 1'b0;
    key_out_ready = 1'b1;
    cyc(TB_DEPTH + 2);
    chk("final_empty", 32'(exp_q.size()), 32'd0);
    popped.delete();

`ifdef KEY_FIFO_AUTOREPEAT_EN
    // Hold 0xA: press plus repeats at hold cycles 20, 28, 36.
    do_reset();
    popped.delete();
    key_out_ready = 1'b1;
    key_code      = 4'hA;
    key_valid     = 1'b1;
    cyc(40);
    key_valid = 1'b0;
    cyc(4);
    chk_popped("autorepeat", '{4'hA, 4'hA, 4'hA, 4'hA});
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
